// File: rtl/vending_pkg.sv
// vending_pkg: shared FSM states, coin unit values and one-hot change codes
package vending_pkg;
    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
    localparam int NICKEL = 1;
    localparam int DIME = 2;
    localparam int QUARTER = 5;
    localparam logic [2:0] CHG_NICKEL = 3'b001;
    localparam logic [2:0] CHG_DIME = 3'b010;
    localparam logic [2:0] CHG_QUARTER = 3'b100;
endpackage

// File: rtl/vm_change_gen.sv
// vm_change_gen: greedy largest-coin-first selector for the remaining credit
module vm_change_gen import vending_pkg::*; #(
    parameter int CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [2:0]          coin,
    output logic [CREDIT_W-1:0] value
);
    always_comb begin
        coin = credit >= CREDIT_W'(QUARTER) ? CHG_QUARTER :
               credit >= CREDIT_W'(DIME)    ? CHG_DIME    :
               credit >= CREDIT_W'(NICKEL)  ? CHG_NICKEL  : 3'b000;
        value = credit >= CREDIT_W'(QUARTER) ? CREDIT_W'(QUARTER) :
                credit >= CREDIT_W'(DIME)    ? CREDIT_W'(DIME)    :
                credit >= CREDIT_W'(NICKEL)  ? CREDIT_W'(NICKEL)  : '0;
    end
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-product vending controller with handshake dispense and greedy change
module vending_machine_multi import vending_pkg::*; #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W = 6,
    parameter int MAX_CREDIT = 40,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {6'd10, 6'd7, 6'd5, 6'd4}
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_nickle,
    input  logic                         i_dime,
    input  logic                         i_quarter,
    input  logic                         i_sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] i_sel,
    input  logic                         i_cancel,
    input  logic                         i_dispense_ready,
    output logic                         o_dispense_valid,
    output logic [$clog2(NUM_ITEMS)-1:0] o_dispense_item,
    output logic [2:0]                   o_change,
    output logic [CREDIT_W-1:0]          o_credit,
    output logic                         o_busy,
    output logic                         o_coin_reject,
    output logic                         o_insufficient
);
    state_t state, next_state;
    logic [CREDIT_W-1:0] credit, next_credit, price_sel, price_q, coin_val, chg_val, chg_val_q;
    logic [2:0] chg_coin;
    logic idle, any_coin, one_coin, fits, sel_in_range, cancel_acc, sel_acc, sel_bad, coin_acc;
    vm_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
        .credit(next_credit),
        .coin  (chg_coin),
        .value (chg_val)
    );
    always_comb begin
        sel_in_range = 1'b0;
        price_sel = '0;
        for (int i = 0; i < NUM_ITEMS; i++)
            if (int'(i_sel) == i) begin
                sel_in_range = 1'b1;
                price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
            end
    end
    always_comb begin
        idle = state == IDLE;
        any_coin = i_nickle | i_dime | i_quarter;
        one_coin = $countones({i_quarter, i_dime, i_nickle}) == 1;
        coin_val = i_quarter ? CREDIT_W'(QUARTER) : i_dime ? CREDIT_W'(DIME) : CREDIT_W'(NICKEL);
        fits = ({1'b0, credit} + {1'b0, coin_val}) <= (CREDIT_W+1)'(MAX_CREDIT);
        cancel_acc = idle && i_cancel && credit != '0;
        sel_acc = idle && !i_cancel && i_sel_valid && sel_in_range && credit >= price_sel;
        sel_bad = idle && !i_cancel && i_sel_valid && !(sel_in_range && credit >= price_sel);
        coin_acc = idle && !cancel_acc && !sel_acc && one_coin && fits;
    end
    always_comb begin
        next_state = state;
        next_credit = credit;
        case (state)
            IDLE: begin
                next_state = cancel_acc ? CHANGE : sel_acc ? VEND : IDLE;
                next_credit = coin_acc ? credit + coin_val : credit;
            end
            VEND: if (i_dispense_ready) begin
                next_credit = credit - price_q;
                next_state = next_credit != '0 ? CHANGE : IDLE;
            end
            CHANGE: begin
                next_credit = credit - chg_val_q;
                next_state = next_credit != '0 ? CHANGE : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            credit <= '0;
            price_q <= '0;
            chg_val_q <= '0;
            o_dispense_item <= '0;
            o_change <= '0;
            o_coin_reject <= 1'b0;
            o_insufficient <= 1'b0;
        end else begin
            state <= next_state;
            credit <= next_credit;
            if (sel_acc) begin
                price_q <= price_sel;
                o_dispense_item <= i_sel;
            end
            o_change <= next_state == CHANGE ? chg_coin : '0;
            chg_val_q <= next_state == CHANGE ? chg_val : '0;
            o_coin_reject <= any_coin && !coin_acc;
            o_insufficient <= sel_bad;
        end
    end
    assign o_dispense_valid = state == VEND;
    assign o_busy = state != IDLE;
    assign o_credit = credit;
endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi: directed self-checking bench for vending_machine_multi
module tb_vending_machine_multi;
    logic clk = 1'b0, rst = 1'b1;
    logic nickle = 0, dime = 0, quarter = 0, sel_valid = 0, cancel = 0, ready = 0;
    logic [1:0] sel = '0;
    logic dispense_valid, busy, coin_reject, insufficient;
    logic [1:0] dispense_item;
    logic [2:0] change;
    logic [5:0] credit;
    int checks = 0, failures = 0, sum;
    vending_machine_multi dut (
        .i_clk(clk), .i_rst(rst), .i_nickle(nickle), .i_dime(dime), .i_quarter(quarter),
        .i_sel_valid(sel_valid), .i_sel(sel), .i_cancel(cancel), .i_dispense_ready(ready),
        .o_dispense_valid(dispense_valid), .o_dispense_item(dispense_item), .o_change(change),
        .o_credit(credit), .o_busy(busy), .o_coin_reject(coin_reject), .o_insufficient(insufficient)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(dispense_valid), 0);
        chk({tag, "_item"}, 32'(dispense_item), 0);
        chk({tag, "_change"}, 32'(change), 0);
        chk({tag, "_credit"}, 32'(credit), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_reject"}, 32'(coin_reject), 0);
        chk({tag, "_insuff"}, 32'(insufficient), 0);
    endtask
    function automatic int coin_value(input logic [2:0] c);
        return c == 3'b100 ? 5 : c == 3'b010 ? 2 : c == 3'b001 ? 1 : 0;
    endfunction
    initial begin
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        // two quarters, buy item 3 (price 10) with ready already high
        quarter = 1; tick(); quarter = 0;
        chk("t1_credit5", 32'(credit), 5);
        quarter = 1; tick(); quarter = 0;
        chk("t1_credit10", 32'(credit), 10);
        sel = 2'd3; sel_valid = 1; ready = 1; tick(); sel_valid = 0;
        chk("t1_valid", 32'(dispense_valid), 1);
        chk("t1_item", 32'(dispense_item), 3);
        chk("t1_busy", 32'(busy), 1);
        tick(); ready = 0;
        chk("t1_valid_drop", 32'(dispense_valid), 0);
        chk("t1_credit0", 32'(credit), 0);
        chk("t1_nochange", 32'(change), 0);
        chk("t1_idle", 32'(busy), 0);
        // dime, quarter, nickel = 8, buy item 1 (price 5), change dime then nickel
        dime = 1; tick(); dime = 0;
        quarter = 1; tick(); quarter = 0;
        nickle = 1; tick(); nickle = 0;
        chk("t2_credit8", 32'(credit), 8);
        sel = 2'd1; sel_valid = 1; tick(); sel_valid = 0;
        chk("t2_valid", 32'(dispense_valid), 1);
        chk("t2_item", 32'(dispense_item), 1);
        ready = 1; tick(); ready = 0;
        chk("t2_valid_drop", 32'(dispense_valid), 0);
        chk("t2_credit3", 32'(credit), 3);
        chk("t2_dime", 32'(change), 3'b010);
        chk("t2_busy", 32'(busy), 1);
        tick();
        chk("t2_credit1", 32'(credit), 1);
        chk("t2_nickel", 32'(change), 3'b001);
        tick();
        chk("t2_credit0", 32'(credit), 0);
        chk("t2_change_end", 32'(change), 0);
        chk("t2_idle", 32'(busy), 0);
        // fill to 38, quarter overflows, nickel fits
        for (int n = 0; n < 7; n++) begin
            quarter = 1; tick(); quarter = 0;
        end
        dime = 1; tick(); dime = 0;
        nickle = 1; tick(); nickle = 0;
        chk("t3_credit38", 32'(credit), 38);
        quarter = 1; tick(); quarter = 0;
        chk("t3_reject", 32'(coin_reject), 1);
        chk("t3_credit_held", 32'(credit), 38);
        nickle = 1; tick(); nickle = 0;
        chk("t3_reject_drop", 32'(coin_reject), 0);
        chk("t3_credit39", 32'(credit), 39);
        cancel = 1; tick(); cancel = 0;
        chk("t3_first_quarter", 32'(change), 3'b100);
        sum = 0;
        for (int n = 0; n < 20 && busy; n++) begin
            sum += coin_value(change);
            tick();
        end
        chk("t3_refund_done", 32'(busy), 0);
        chk("t3_refund_sum", 32'(sum), 39);
        chk("t3_credit0", 32'(credit), 0);
        // two coins at once rejected, then insufficient credit
        nickle = 1; dime = 1; tick(); nickle = 0; dime = 0;
        chk("t4_multi_reject", 32'(coin_reject), 1);
        chk("t4_multi_credit", 32'(credit), 0);
        dime = 1; tick(); dime = 0;
        chk("t4_credit2", 32'(credit), 2);
        chk("t4_reject_clear", 32'(coin_reject), 0);
        sel = 2'd0; sel_valid = 1; tick(); sel_valid = 0;
        chk("t4_insuff", 32'(insufficient), 1);
        chk("t4_no_vend", 32'(dispense_valid), 0);
        chk("t4_idle", 32'(busy), 0);
        chk("t4_credit_kept", 32'(credit), 2);
        tick();
        chk("t4_insuff_drop", 32'(insufficient), 0);
        cancel = 1; tick(); cancel = 0;
        chk("t4_refund_dime", 32'(change), 3'b010);
        tick();
        chk("t4_refund_end", 32'(change), 0);
        chk("t4_refund_credit", 32'(credit), 0);
        // credit 7, cancel beats select; coin during CHANGE rejected
        quarter = 1; tick(); quarter = 0;
        dime = 1; tick(); dime = 0;
        chk("t5_credit7", 32'(credit), 7);
        sel = 2'd0; sel_valid = 1; cancel = 1; tick(); sel_valid = 0; cancel = 0;
        chk("t5_no_vend", 32'(dispense_valid), 0);
        chk("t5_busy", 32'(busy), 1);
        chk("t5_quarter", 32'(change), 3'b100);
        chk("t5_credit7b", 32'(credit), 7);
        nickle = 1; tick(); nickle = 0;
        chk("t5_busy_reject", 32'(coin_reject), 1);
        chk("t5_dime", 32'(change), 3'b010);
        chk("t5_credit2", 32'(credit), 2);
        tick();
        chk("t5_change_end", 32'(change), 0);
        chk("t5_credit0", 32'(credit), 0);
        chk("t5_idle", 32'(busy), 0);
        chk("t5_no_vend_end", 32'(dispense_valid), 0);
        // stall in VEND, then reset in the middle of CHANGE
        quarter = 1; tick(); quarter = 0;
        quarter = 1; tick(); quarter = 0;
        sel = 2'd2; sel_valid = 1; tick(); sel_valid = 0; sel = 2'd0;
        for (int n = 0; n < 5; n++) begin
            chk("t6_hold_valid", 32'(dispense_valid), 1);
            chk("t6_hold_item", 32'(dispense_item), 2);
            tick();
        end
        ready = 1; tick(); ready = 0;
        chk("t6_credit3", 32'(credit), 3);
        chk("t6_dime", 32'(change), 3'b010);
        #2 rst = 1'b1;
        #1 chk_all_zero("t6_async_rst");
        tick(); rst = 1'b0; tick();
        chk("t6_post_credit", 32'(credit), 0);
        chk("t6_post_change", 32'(change), 0);
        chk("t6_post_busy", 32'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
